// File: rtl/fcl_pro_stream.sv
// Streaming binary-weight FC lane array with group framing.
// Saturating accumulate, shift/sign output stage, valid/ready back-pressure.
module fcl_pro_stream #(
  parameter int PIX_W   = 8,
  parameter int PAR     = 16,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int MAX_LEN = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIX_W-1:0]             in_pixel,
  input  logic [PAR-1:0]               in_w,
  input  logic                         in_last,
  input  logic [$clog2(ACC_W)-1:0]     shift,
  input  logic                         bin_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAR*OUT_W-1:0]         out_data,
  output logic [PAR-1:0]               out_sat,
  output logic [$clog2(MAX_LEN+1)-1:0] out_cnt
);

  localparam int CNT_W = $clog2(MAX_LEN+1);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t state_q, state_d;

  logic [PAR-1:0][ACC_W-1:0] acc_q;
  logic [PAR-1:0][ACC_W-1:0] sum;
  logic [PAR-1:0][OUT_W-1:0] y;
  logic [PAR-1:0]            sat_q;
  logic [PAR-1:0]            clip;
  logic [PAR-1:0]            oclip;
  logic [PAR-1:0]            fsat;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_nx;
  logic [PAR*OUT_W-1:0]      data_q;
  logic [PAR-1:0]            osat_q;
  logic [CNT_W-1:0]          ocnt_q;
  logic                      take;
  logic                      first;
  logic                      grp_end;

  assign out_valid = (state_q == S_OUT);
  assign in_ready  = !out_valid || out_ready;
  assign take      = in_valid && in_ready;
  assign first     = (cnt_q == '0);
  assign cnt_nx    = cnt_q + CNT_W'(1);
  assign grp_end   = take &&
                     (in_last || cnt_nx == CNT_W'(MAX_LEN));

  assign out_data = data_q;
  assign out_sat  = osat_q;
  assign out_cnt  = ocnt_q;

  for (genvar i = 0; i < PAR; i++) begin : g_lane
    logic signed [ACC_W-1:0] pix;
    logic signed [ACC_W-1:0] c;
    logic        [ACC_W-1:0] base;
    logic        [ACC_W:0]   s;
    logic signed [ACC_W-1:0] sh;
    logic [ACC_W-OUT_W:0]    hi;
    logic                    fit;
    logic                    ovf;

    assign pix  = {{(ACC_W-PIX_W){in_pixel[PIX_W-1]}}, in_pixel};
    assign c    = in_w[i] ? pix : -pix;
    assign base = first ? '0 : acc_q[i];
    assign s    = {base[ACC_W-1], base} + {c[ACC_W-1], c};
    assign ovf  = s[ACC_W] ^ s[ACC_W-1];
    assign sum[i] = ovf ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}}
                        : s[ACC_W-1:0];
    assign clip[i] = ovf;

    assign sh  = $signed(sum[i]) >>> shift;
    assign hi  = sh[ACC_W-1:OUT_W-1];
    assign fit = (&hi) | ~(|hi);
    assign oclip[i] = ~fit;

    // Sign-binarize maps zero to +1.
    assign y[i] = bin_mode ? (sum[i][ACC_W-1] ? '1 : OUT_W'(1))
                : fit      ? sh[OUT_W-1:0]
                : {sh[ACC_W-1], {(OUT_W-1){~sh[ACC_W-1]}}};
    assign fsat[i] = sat_q[i] | clip[i] | (~bin_mode & oclip[i]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACC: if (grp_end) state_d = S_OUT;
      S_OUT: if (out_ready) state_d = grp_end ? S_OUT : S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_ACC;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      sat_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      osat_q <= '0;
      ocnt_q <= '0;
    end else if (grp_end) begin
      acc_q  <= '0;
      sat_q  <= '0;
      cnt_q  <= '0;
      data_q <= y;
      osat_q <= fsat;
      ocnt_q <= cnt_nx;
    end else if (take) begin
      acc_q  <= sum;
      sat_q  <= sat_q | clip;
      cnt_q  <= cnt_nx;
    end
  end

endmodule
